// File: rtl/seq_mult_ctrl.sv
// seq_mult_ctrl: shift-and-add unsigned WxW multiplier reusing one 2W-bit ripple-carry adder over W cycles
module full_adder (
  input  logic i_x,
  input  logic i_y,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_x ^ i_y ^ i_c;
  assign o_c = (i_x & i_y) | (i_c & (i_x ^ i_y));
endmodule

module seq_mult_ctrl #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_start,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic           o_busy,
  output logic           o_done,
  output logic [2*W-1:0] o_p
);
  localparam int CW = $clog2(W) + 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t           r_state, w_next;
  logic [2*W-1:0]   r_mcand, r_acc, w_addend, w_sum;
  logic [W-1:0]     r_mplier;
  logic [CW-1:0]    r_cnt;
  logic [2*W-1:0]   w_carry;
  logic             w_accept, w_last;
  assign w_accept = (r_state == IDLE) && i_start;
  assign w_last   = (r_state == CALC) && (r_cnt == CW'(W - 1));
  assign w_addend = r_mplier[0] ? r_mcand : '0;
  assign w_carry[0] = 1'b0;
  // Shared adder; the top stage drops its carry since the product never exceeds 2W bits.
  for (genvar i = 0; i < 2*W; i++) begin : g_fa
    if (i < 2*W - 1) begin : g_full
      full_adder u_fa (
        .i_x(r_acc[i]),
        .i_y(w_addend[i]),
        .i_c(w_carry[i]),
        .o_s(w_sum[i]),
        .o_c(w_carry[i+1])
      );
    end else begin : g_msb
      assign w_sum[i] = r_acc[i] ^ w_addend[i] ^ w_carry[i];
    end
  end
  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  // Next-state: fixed W-step CALC, single DONE cycle, start honoured only in IDLE.
  always_comb begin
    w_next = r_state;
    w_next = w_accept ? CALC :
             w_last ? DONE :
             (r_state == DONE) ? IDLE : r_state;
  end
  // Datapath: capture operands, accumulate one partial product per CALC edge, publish result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      o_p      <= '0;
      o_done   <= 1'b0;
      o_busy   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mcand  <= {{W{1'b0}}, i_a};
        r_mplier <= i_b;
        r_acc    <= '0;
        r_cnt    <= '0;
        o_busy   <= 1'b1;
      end
      if (r_state == CALC) begin
        r_acc    <= w_sum;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 1'b1;
        if (w_last) begin
          o_p    <= w_sum;
          o_done <= 1'b1;
        end
      end
      if (r_state == DONE) begin
        o_done <= 1'b0;
        o_busy <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_seq_mult_ctrl.sv
// tb_seq_mult_ctrl: directed scenario checks of seq_mult_ctrl at W=4 and W=8
module tb_seq_mult_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_start = 1'b0, i_start8 = 1'b0;
  logic [3:0]  i_a = '0, i_b = '0;
  logic [7:0]  i_a8 = '0, i_b8 = '0;
  logic        o_busy, o_done, o_busy8, o_done8;
  logic [7:0]  o_p;
  logic [15:0] o_p8;
  int vec = 0, errs = 0;

  seq_mult_ctrl #(.W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_a(i_a), .i_b(i_b),
    .o_busy(o_busy), .o_done(o_done), .o_p(o_p)
  );
  seq_mult_ctrl #(.W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .i_start(i_start8), .i_a(i_a8), .i_b(i_b8),
    .o_busy(o_busy8), .o_done(o_done8), .o_p(o_p8)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One start pulse; reports cycles from acceptance to done, p at done, and busy cycles.
  task automatic mult_op(input logic [3:0] a, input logic [3:0] b,
                         output int lat, output logic [7:0] pv, output int bcyc);
    i_a = a; i_b = b; i_start = 1'b1;
    tick;
    i_start = 1'b0;
    lat = -1; pv = 'x; bcyc = 0;
    for (int j = 0; j <= 40; j++) begin
      if (o_done && lat < 0) begin lat = j; pv = o_p; end
      if (!o_busy) break;
      bcyc++;
      tick;
    end
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    vec++; if (o_busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", o_busy); end
    vec++; if (o_done !== 1'b0) begin errs++; $display("FAIL reset_done got %b want 0", o_done); end
    vec++; if (o_p !== 8'h00) begin errs++; $display("FAIL reset_p got %h want 00", o_p); end
    vec++; if (o_p8 !== 16'h0000 || o_busy8 !== 1'b0) begin errs++; $display("FAIL reset_w8 got p=%h busy=%b want p=0000 busy=0", o_p8, o_busy8); end
    tick; tick;
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int lat, bc; logic [7:0] pv;
    mult_op(4'd3, 4'd2, lat, pv, bc);
    vec++; if (pv !== 8'd6) begin errs++; $display("FAIL basic_p got %0d want 6", pv); end
    vec++; if (lat != 4) begin errs++; $display("FAIL basic_latency got %0d want 4", lat); end
    vec++; if (bc != 5) begin errs++; $display("FAIL basic_busy_cycles got %0d want 5", bc); end
    vec++; if (o_p !== 8'd6 || o_done !== 1'b0) begin errs++; $display("FAIL basic_hold got p=%0d done=%b want p=6 done=0", o_p, o_done); end
  endtask

  task automatic test_max;
    int lat, bc; logic [7:0] pv;
    mult_op(4'd15, 4'd15, lat, pv, bc);
    vec++; if (pv !== 8'hE1) begin errs++; $display("FAIL max_p got %h want e1", pv); end
    vec++; if (lat != 4 || bc != 5) begin errs++; $display("FAIL max_timing got lat=%0d busy=%0d want lat=4 busy=5", lat, bc); end
  endtask

  task automatic test_zero;
    int lat, bc; logic [7:0] pv;
    mult_op(4'd0, 4'd9, lat, pv, bc);
    vec++; if (pv !== 8'd0) begin errs++; $display("FAIL zero_a_p got %0d want 0", pv); end
    vec++; if (lat != 4) begin errs++; $display("FAIL zero_a_latency got %0d want 4", lat); end
    mult_op(4'd7, 4'd7, lat, pv, bc);
    vec++; if (pv !== 8'd49) begin errs++; $display("FAIL mid_p got %0d want 49", pv); end
    mult_op(4'd9, 4'd0, lat, pv, bc);
    vec++; if (pv !== 8'd0) begin errs++; $display("FAIL zero_b_p got %0d want 0", pv); end
    vec++; if (lat != 4) begin errs++; $display("FAIL zero_b_latency got %0d want 4", lat); end
  endtask

  task automatic test_ignore_start;
    int dones = 0;
    i_a = 4'd5; i_b = 4'd7; i_start = 1'b1;
    tick;
    i_start = 1'b0;
    tick;
    i_a = 4'd1; i_b = 4'd1; i_start = 1'b1;
    tick;
    i_start = 1'b0;
    tick;
    vec++; if (o_done !== 1'b0) begin errs++; $display("FAIL ign_early_done got %b want 0", o_done); end
    tick;
    vec++; if (o_done !== 1'b1 || o_p !== 8'd35) begin errs++; $display("FAIL ign_done got done=%b p=%0d want done=1 p=35", o_done, o_p); end
    i_start = 1'b1;
    tick;
    i_start = 1'b0;
    vec++; if (o_busy !== 1'b0 || o_done !== 1'b0) begin errs++; $display("FAIL ign_end got busy=%b done=%b want 0 0", o_busy, o_done); end
    for (int j = 0; j < 8; j++) begin
      if (o_done || o_busy) dones++;
      tick;
    end
    vec++; if (dones != 0 || o_p !== 8'd35) begin errs++; $display("FAIL ign_no_restart got activity=%0d p=%0d want 0 35", dones, o_p); end
  endtask

  task automatic test_async_reset;
    int lat, bc, act = 0; logic [7:0] pv;
    i_a = 4'd6; i_b = 4'd6; i_start = 1'b1;
    tick;
    i_start = 1'b0;
    tick; tick;
    #2 rst_n = 1'b0;
    #1;
    vec++; if (o_busy !== 1'b0 || o_done !== 1'b0 || o_p !== 8'd0) begin errs++; $display("FAIL arst_immediate got busy=%b done=%b p=%0d want 0 0 0", o_busy, o_done, o_p); end
    for (int j = 0; j < 6; j++) begin
      tick;
      if (o_done || o_busy) act++;
      if (j == 2) rst_n = 1'b1;
    end
    vec++; if (act != 0) begin errs++; $display("FAIL arst_no_done got %0d active cycles want 0", act); end
    mult_op(4'd2, 4'd3, lat, pv, bc);
    vec++; if (pv !== 8'd6 || lat != 4) begin errs++; $display("FAIL arst_after got p=%0d lat=%0d want 6 4", pv, lat); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] e;
    i_start = 1'b1;
    for (int n = 0; n < 256; n++) begin
      i_a = n[7:4]; i_b = n[3:0];
      e = 8'(n[7:4] * n[3:0]);
      tick;
      for (int j = 1; j < 4; j++) tick;
      vec++; if (o_done !== 1'b0) begin errs++; $display("FAIL b2b_early n=%0d got done=%b want 0", n, o_done); end
      tick;
      vec++; if (o_done !== 1'b1 || o_p !== e) begin errs++; $display("FAIL b2b_p n=%0d got done=%b p=%0d want done=1 p=%0d", n, o_done, o_p, e); end
      tick;
      vec++; if (o_done !== 1'b0 || o_busy !== 1'b0) begin errs++; $display("FAIL b2b_gap n=%0d got done=%b busy=%b want 0 0", n, o_done, o_busy); end
    end
    i_start = 1'b0;
    tick;
  endtask

  task automatic test_random_w8;
    logic [15:0] e;
    int ra, rb;
    i_start8 = 1'b1;
    for (int n = 0; n < 40; n++) begin
      ra = (n == 0) ? 255 : int'($urandom_range(0, 255));
      rb = (n == 0) ? 255 : int'($urandom_range(0, 255));
      i_a8 = 8'(ra); i_b8 = 8'(rb);
      e = 16'(ra * rb);
      tick;
      for (int j = 1; j < 8; j++) tick;
      vec++; if (o_done8 !== 1'b0) begin errs++; $display("FAIL w8_early n=%0d got done=%b want 0", n, o_done8); end
      tick;
      vec++; if (o_done8 !== 1'b1 || o_p8 !== e) begin errs++; $display("FAIL w8_p %0d*%0d got done=%b p=%0d want done=1 p=%0d", ra, rb, o_done8, o_p8, e); end
      tick;
      vec++; if (o_done8 !== 1'b0 || o_busy8 !== 1'b0) begin errs++; $display("FAIL w8_gap n=%0d got done=%b busy=%b want 0 0", n, o_done8, o_busy8); end
    end
    i_start8 = 1'b0;
    tick;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_max;
    test_zero;
    test_ignore_start;
    test_async_reset;
    test_back_to_back;
    test_random_w8;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/seq_mult_ctrl.md
# seq_mult_ctrl

Sequential shift-and-add multiplier controller. It sequences a single shared 2W-bit ripple-carry adder, built from the team's full-adder cells, over W cycles to form an unsigned W×W product. It generalises the combinational 2×2 array multiplier to arbitrary width while spending one adder instead of an array. A start/busy/done handshake lets a host issue one multiply at a time.

## Interface
- W, default 4: operand width in bits, legal range 2..16.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  request a multiply; sampled only in IDLE.
- a  input  W  multiplicand; captured on the accepting edge.
- b  input  W  multiplier; captured on the accepting edge.
- busy  output  1  high while an operation is in flight, including the DONE cycle.
- done  output  1  one-cycle pulse; p is valid and newly updated.
- p  output  2W  unsigned product of the last completed operation.

## Operation
- FSM states: IDLE, CALC, DONE.
- Registers:
  - mcand (2W): zero-extended multiplicand.
  - mplier (W): multiplier.
  - acc (2W): running sum.
  - cnt: iteration count, $clog2(W)+1 bits.
  - p (2W), done, busy.
- IDLE:
  - If start=1 at an edge: mcand ← {W'b0, a}, mplier ← b, acc ← 0, cnt ← 0, busy ← 1, go to CALC.
  - Otherwise hold.
- CALC, each edge:
  - If mplier[0]=1: acc ← acc + mcand through the shared adder; else acc unchanged.
  - Then mcand ← mcand << 1, mplier ← mplier >> 1, cnt ← cnt + 1.
  - The edge with cnt = W-1 performs the final step. On that same edge: p ← final acc value (including that step's add), done ← 1, go to DONE.
- DONE:
  - Next edge: done ← 0, busy ← 0, go to IDLE.
- Arithmetic:
  - Unsigned only.
  - The adder is 2W bits wide with carry-in tied to 0.
  - The adder's carry-out is discarded. It is provably 0, since the product is at most (2^W−1)^2 < 2^2W.
- No early termination: latency is independent of operand values, including zero operands.
- start is ignored in CALC and DONE. It is not queued.
- a and b may change freely after the accepting edge.
- p holds its value until the next operation completes. It is not cleared on start.

## Timing
- Reset (rst_n=0, asynchronous, any state):
  - Outputs: busy=0, done=0, p=0.
  - State and registers: state=IDLE; acc, mcand, mplier, cnt all 0.
  - An in-flight operation is abandoned with no done pulse.
- Reset release: the first edge with rst_n=1 may accept start.
- Accepting edge = edge k (start=1, state IDLE).
- CALC steps occur on edges k+1 … k+W.
- busy:
  - Rises after edge k.
  - Falls after edge k+W+1.
  - High for W+1 cycles total.
- done:
  - High exactly one cycle, from edge k+W to edge k+W+1.
  - p changes after edge k+W, simultaneously with done rising.
- Back-to-back operation:
  - start held high continuously is accepted on edge k+W+2, the first edge in IDLE.
  - The next done arrives after edge k+2W+2.
  - Throughput: one product per W+2 cycles.
- start asserted during the DONE cycle is ignored.

## Test plan
- W=4, reset then a=3, b=2, start pulse on edge k:
  - busy high for 5 cycles.
  - done pulses after edge k+4.
  - p=6.
- W=4, a=15, b=15:
  - p=225 (8'hE1).
  - No corruption of the high bits; same latency as above.
- W=4, a=0, b=9, then a=9, b=0:
  - Each gives p=0.
  - done still arrives exactly W cycles after acceptance, showing no early exit.
- W=4, a=5, b=7 accepted:
  - Pulse start with a=1, b=1 at edge k+2 (in CALC).
  - Pulse start again in the DONE cycle.
  - Required: both ignored; a single done with p=35; busy then falls.
- W=4, a=6, b=6 accepted:
  - Assert rst_n=0 asynchronously mid-cycle after edge k+2.
  - Required: busy, done and p are 0 immediately; no done pulse.
  - After release, a=2, b=3 yields p=6 on schedule.
- Random sweep, W=4 exhaustive over all 256 pairs and W=8 random:
  - start held high continuously.
  - Required: every done pulse is W+2 cycles apart, and each p equals a×b of its accepted operands.
